// File: rtl/vote_booth_arbiter.sv
// Round-robin booth sequencer feeding one vote-cast port. Grant lands 1 cycle after request.
// cast_valid holds until cast_ready. Optional abstain handling is under `VOTE_ABSTAIN_EN.
module vote_booth_arbiter #(
  parameter int NUM_BOOTHS  = 4,
  parameter int TIMEOUT_CYC = 64,
  parameter int STABLE_CYC  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    session_open,
  input  logic [NUM_BOOTHS-1:0]   booth_req,
  input  logic [NUM_BOOTHS*4-1:0] booth_code,
  output logic [NUM_BOOTHS-1:0]   booth_grant,
  output logic [NUM_BOOTHS-1:0]   booth_done,
  output logic [NUM_BOOTHS-1:0]   booth_reject,
  output logic [NUM_BOOTHS-1:0]   booth_timeout,
  output logic                    cast_valid,
  output logic [1:0]              cast_cand,
  input  logic                    cast_ready,
  output logic [11:0]             invalid_cnt,
  output logic [11:0]             abstain_cnt,
  output logic                    busy
);
  localparam int IW = (NUM_BOOTHS > 1) ? $clog2(NUM_BOOTHS) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int SW = $clog2(STABLE_CYC + 1);

  typedef enum logic [2:0] {IDLE, GRANT, SETTLE, CAST, RELEASE} state_t;

  state_t                state, state_nxt;
  logic [IW-1:0]         ptr, ptr_nxt;
  logic [NUM_BOOTHS-1:0] grant_nxt, done_nxt, reject_nxt, timeout_nxt;
  logic [TW-1:0]         tcnt, tcnt_nxt;
  logic [SW-1:0]         scnt, scnt_nxt;
  logic [3:0]            cap, cap_nxt, code;
  logic [1:0]            cand_nxt;
  logic [11:0]           inv_nxt;
  logic                  pick_vld, cap_onehot;
  logic [IW-1:0]         pick_idx;

  // ptr always names the booth currently (or most recently) granted
  assign code       = booth_code[{ptr, 2'b00} +: 4];
  assign cap_onehot = (cap != 4'd0) && ((cap & (cap - 4'd1)) == 4'd0);
  assign cast_valid = (state == CAST);
  assign busy       = (state != IDLE);

`ifdef VOTE_ABSTAIN_EN
  logic [11:0] abs_nxt;
`else
  assign abstain_cnt = '0;
`endif

  always_comb begin : arb
    int idx;
    pick_vld = 1'b0;
    pick_idx = '0;
    idx      = 0;
    for (int i = 1; i <= NUM_BOOTHS; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_BOOTHS) idx = idx - NUM_BOOTHS;
      if (!pick_vld && booth_req[IW'(idx)]) begin
        pick_vld = 1'b1;
        pick_idx = IW'(idx);
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    grant_nxt   = booth_grant;
    done_nxt    = '0;
    reject_nxt  = '0;
    timeout_nxt = '0;
    tcnt_nxt    = tcnt;
    scnt_nxt    = scnt;
    cap_nxt     = cap;
    cand_nxt    = cast_cand;
    inv_nxt     = invalid_cnt;
`ifdef VOTE_ABSTAIN_EN
    abs_nxt     = abstain_cnt;
`endif
    case (state)
      IDLE: begin
        if (session_open && pick_vld) begin
          state_nxt           = GRANT;
          ptr_nxt             = pick_idx;
          grant_nxt           = '0;
          grant_nxt[pick_idx] = 1'b1;
          tcnt_nxt            = '0;
        end
      end
      GRANT: begin
        if (code == 4'd0) begin
          if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
            timeout_nxt = booth_grant;
            grant_nxt   = '0;
            state_nxt   = IDLE;
          end else begin
            tcnt_nxt = tcnt + 1'b1;
          end
        end else begin
          cap_nxt   = code;
          scnt_nxt  = SW'(1);
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        // timeout count is deliberately kept across a bounce back to GRANT
        if (code == 4'd0) begin
          state_nxt = GRANT;
        end else if (code != cap) begin
          cap_nxt  = code;
          scnt_nxt = SW'(1);
        end else if (int'(scnt) + 1 >= STABLE_CYC) begin
          if (cap_onehot) begin
            state_nxt = CAST;
            case (cap)
              4'b0010: cand_nxt = 2'd1;
              4'b0100: cand_nxt = 2'd2;
              4'b1000: cand_nxt = 2'd3;
              default: cand_nxt = 2'd0;
            endcase
`ifdef VOTE_ABSTAIN_EN
          end else if (cap == 4'hF) begin
            done_nxt  = booth_grant;
            state_nxt = RELEASE;
            if (abstain_cnt != 12'hFFF) abs_nxt = abstain_cnt + 12'd1;
`endif
          end else begin
            reject_nxt = booth_grant;
            state_nxt  = RELEASE;
            if (invalid_cnt != 12'hFFF) inv_nxt = invalid_cnt + 12'd1;
          end
        end else begin
          scnt_nxt = scnt + 1'b1;
        end
      end
      CAST: begin
        if (cast_ready) begin
          done_nxt  = booth_grant;
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        // hold the grant until the key is let go so one press cannot vote twice
        if (code == 4'd0) begin
          grant_nxt = '0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= IW'(NUM_BOOTHS - 1);
      booth_grant   <= '0;
      booth_done    <= '0;
      booth_reject  <= '0;
      booth_timeout <= '0;
      tcnt          <= '0;
      scnt          <= '0;
      cap           <= '0;
      cast_cand     <= '0;
      invalid_cnt   <= '0;
    end else begin
      state         <= state_nxt;
      ptr           <= ptr_nxt;
      booth_grant   <= grant_nxt;
      booth_done    <= done_nxt;
      booth_reject  <= reject_nxt;
      booth_timeout <= timeout_nxt;
      tcnt          <= tcnt_nxt;
      scnt          <= scnt_nxt;
      cap           <= cap_nxt;
      cast_cand     <= cand_nxt;
      invalid_cnt   <= inv_nxt;
    end
  end

`ifdef VOTE_ABSTAIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) abstain_cnt <= '0;
    else        abstain_cnt <= abs_nxt;
  end
`endif

endmodule

// File: doc/vote_booth_arbiter.md
Name: vote_booth_arbiter

Overview:
- Sequencer that lets several voting booths share one vote-counter datapath.
- Grants one booth at a time (round-robin), waits for a stable 4-bit candidate code, validates it as one-hot, issues one cast transaction downstream, then releases the booth once its input returns to zero.
- Sits between the booth keypads and the vote tally/display block.

Parameters:
- NUM_BOOTHS, 4, number of requesting booths (2..8).
- TIMEOUT_CYC, 64, cycles a granted booth may stay idle (code==0) before its grant is revoked.
- STABLE_CYC, 2, consecutive cycles a nonzero code must hold unchanged before it is evaluated.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- session_open  in  1  level; 1 = voting open, new grants allowed.
- booth_req  in  NUM_BOOTHS  per-booth request, level.
- booth_code  in  NUM_BOOTHS*4  per-booth candidate code; booth i uses bits [4i+3:4i].
- booth_grant  out  NUM_BOOTHS  one-hot grant, registered.
- booth_done  out  NUM_BOOTHS  1-cycle pulse to the granted booth: vote accepted.
- booth_reject  out  NUM_BOOTHS  1-cycle pulse: invalid code.
- booth_timeout  out  NUM_BOOTHS  1-cycle pulse: grant revoked on timeout.
- cast_valid  out  1  vote-cast request to the counter datapath.
- cast_cand  out  2  candidate index (bit position of the one-hot code).
- cast_ready  in  1  datapath accepts the cast.
- invalid_cnt  out  12  rejected-ballot count, saturating.
- abstain_cnt  out  12  abstain count (see Optional Feature).
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; all outputs 0; both counters 0.
  - Round-robin pointer = NUM_BOOTHS-1, so booth 0 wins first.
- IDLE:
  - If session_open=1 and any booth_req is set, pick the first requesting booth after the pointer (wrapping).
  - Set its booth_grant bit on the next edge, update the pointer to that booth, clear the timeout counter, go to GRANT.
- GRANT:
  - Each cycle the granted code==0: the timeout counter increments.
  - When the counter reaches TIMEOUT_CYC-1 with code still 0: pulse booth_timeout, drop the grant, go to IDLE.
  - Code nonzero: capture it, set stable count=1, go to SETTLE.
- SETTLE:
  - Code equal to the captured value: increment stable count.
  - Code changes to a different nonzero value: recapture it, stable count=1.
  - Code becomes 0: return to GRANT. The timeout counter keeps counting; it is not reset.
  - Stable count reaches STABLE_CYC: evaluate the captured code.
    - Exactly one bit set: go to CAST.
    - Anything else: pulse booth_reject, invalid_cnt+1 (saturating at 4095), go to RELEASE.
- CAST:
  - cast_valid=1 and cast_cand=index are held stable until cast_ready=1 at a clock edge.
  - That edge completes the transfer: cast_valid drops, booth_done pulses, go to RELEASE.
  - Exactly one cast per grant.
- RELEASE:
  - Grant stays held until the granted code==0.
  - Then drop the grant and go to IDLE. This prevents a held key from double-voting.
- booth_req changes while a booth is granted: ignored.
- session_open falls mid-transaction: the current transaction completes normally; no new grant is issued.
- Minimum turnaround between grants: 1 IDLE cycle.
- Simultaneous requests are resolved purely by the pointer; an ungranted booth's code is ignored.
- Outputs booth_done, booth_reject and booth_timeout are mutually exclusive and only ever on the granted booth's bit.

Optional Feature:
- Macro: VOTE_ABSTAIN_EN.
- Defined:
  - Code 4'b1111, once stable, counts as an abstention: abstain_cnt+1 (saturating), booth_done pulses, go to RELEASE.
  - No cast is issued and invalid_cnt is unchanged.
- Undefined:
  - 4'b1111 is rejected like any other non-one-hot code.
  - abstain_cnt is tied to 0.

Test Plan:
- Reset, session_open=1, req=4'b0001, booth0 code 0001 held 3 cycles, cast_ready=1 -> grant=0001; cast_valid with cast_cand=0 for 1 cycle; booth_done[0]; grant drops after code returns to 0; invalid_cnt=0.
- req=4'b1111 held, each booth votes once in turn -> grant order 0,1,2,3,0; one cast each.
- Booth granted, code 0101 stable -> booth_reject pulse, no cast_valid, invalid_cnt=1; grant held until code=0.
- Granted booth keeps code 0 for 64 cycles -> booth_timeout pulse on cycle 64, grant cleared, state IDLE.
- Code 0010 stable with cast_ready=0 for 5 cycles, then 1 -> cast_valid held 6 cycles with cast_cand=1 constant; exactly one done pulse.
- Code 1111 -> with VOTE_ABSTAIN_EN: abstain_cnt=1, booth_done pulse; without it: invalid_cnt+1, booth_reject pulse.
- rst_n pulled low during CAST -> all outputs 0 immediately; the next grant goes to booth 0.
